// File: rtl/hmmm_mem_server.sv
// hmmm_mem_server: 256 x 15-bit unified memory, core bus responder and
// byte-stream program loader that holds the core in reset while loading.
// Ports:
//   ph1, ph2      two-phase clock (ph2 samples, ph1 updates)
//   reset         synchronous, active-high, sampled on ph2
//   Adr, MemWrite core address and store strobe
//   MemData1      word bits [14:8] of mem[Adr]
//   MemData2      word bits [7:0]; tri-stated during a RUN-state store
//   cpu_reset     registered reset to the core (high unless running)
//   ld_valid, ld_data, ld_last, ld_ready  loader byte handshake
//   reload_req    return from RUN to loading at address 0
//   ld_count      next load address
//   run           high in RUN state
module hmmm_mem_server (
    input  logic       ph1,
    input  logic       ph2,
    input  logic       reset,
    input  logic [7:0] Adr,
    input  logic       MemWrite,
    output logic [6:0] MemData1,
    inout  wire  [7:0] MemData2,
    output logic       cpu_reset,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    input  logic       reload_req,
    output logic [7:0] ld_count,
    output logic       run
);

    localparam logic [1:0] S_HI  = 2'd0;
    localparam logic [1:0] S_LO  = 2'd1;
    localparam logic [1:0] S_RUN = 2'd2;

    logic [14:0] mem [256];

    // Slave (ph1) registers: the architecturally visible state.
    logic [1:0] state;
    logic [7:0] waddr;
    logic [6:0] hi;

    // Master (ph2) registers: capture next state while ph2 samples.
    logic [1:0] state_m;
    logic [7:0] waddr_m;
    logic [6:0] hi_m;
    logic       cpu_reset_m;

    logic [1:0] state_n;
    logic [7:0] waddr_n;
    logic [6:0] hi_n;

    logic        ld_we;
    logic        st_we;
    logic [14:0] rd;

    assign run      = (state == S_RUN);
    assign ld_ready = ~run;
    assign ld_count = waddr;

    assign ld_we = ~reset & ld_valid & (state == S_LO);
    assign st_we = run & MemWrite;

    always_comb begin
        state_n = state;
        waddr_n = waddr;
        hi_n    = hi;
        if (reset) begin
            state_n = S_HI;
            waddr_n = 8'd0;
            hi_n    = 7'd0;
        end else begin
            unique case (state)
                S_HI: begin
                    if (ld_valid) begin
                        hi_n    = ld_data[6:0];
                        state_n = S_LO;
                    end
                end
                S_LO: begin
                    if (ld_valid) begin
                        // Natural 8-bit wrap takes 255 back to 0 on the
                        // final word of a full memory image.
                        waddr_n = waddr + 8'd1;
                        if (ld_last || waddr == 8'd255) begin
                            state_n = S_RUN;
                        end else begin
                            state_n = S_HI;
                        end
                    end
                end
                S_RUN: begin
                    if (reload_req) begin
                        state_n = S_HI;
                        waddr_n = 8'd0;
                    end
                end
                default: begin
                    state_n = S_HI;
                end
            endcase
        end
    end

    always_ff @(posedge ph2) begin
        state_m     <= state_n;
        waddr_m     <= waddr_n;
        hi_m        <= hi_n;
        cpu_reset_m <= (state_n != S_RUN);
    end

    always_ff @(posedge ph1) begin
        state     <= state_m;
        waddr     <= waddr_m;
        hi        <= hi_m;
        cpu_reset <= cpu_reset_m;
    end

    // Loader and core stores never coincide: one needs LOAD_LO, the
    // other RUN. A core store only touches the low byte.
    always_ff @(posedge ph2) begin
        if (ld_we) begin
            mem[waddr] <= {hi, ld_data};
        end
        if (st_we) begin
            mem[Adr][7:0] <= MemData2;
        end
    end

    assign rd       = mem[Adr];
    assign MemData1 = rd[14:8];
    assign MemData2 = st_we ? 8'bz : rd[7:0];

endmodule

// File: tb/tb_hmmm_mem_server.sv
// tb_hmmm_mem_server: directed plus randomized checks of hmmm_mem_server
// against a word-level memory image model.
module tb_hmmm_mem_server;

    logic       ph1;
    logic       ph2;
    logic       reset;
    logic [7:0] Adr;
    logic       MemWrite;
    logic [6:0] MemData1;
    wire  [7:0] MemData2;
    logic       cpu_reset;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       reload_req;
    logic [7:0] ld_count;
    logic       run;

    logic       core_en;
    logic [7:0] core_dat;

    assign MemData2 = core_en ? core_dat : 8'bz;

    hmmm_mem_server dut (
        .ph1        (ph1),
        .ph2        (ph2),
        .reset      (reset),
        .Adr        (Adr),
        .MemWrite   (MemWrite),
        .MemData1   (MemData1),
        .MemData2   (MemData2),
        .cpu_reset  (cpu_reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .reload_req (reload_req),
        .ld_count   (ld_count),
        .run        (run)
    );

    // Period 10: ph1 high 1..3, ph2 high 6..8 (non-overlapping).
    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        forever begin
            #1 ph1 = 1'b1;
            #2 ph1 = 1'b0;
            #3 ph2 = 1'b1;
            #2 ph2 = 1'b0;
            #2;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int passed = 0;
    int total  = 0;

    // Reference image: contents plus which halves are known.
    logic [14:0] mm [256];
    logic        khi [256];
    logic        klo [256];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One cycle: ph2 samples inputs, ph1 updates; returns just after ph1.
    task automatic tick();
        @(posedge ph2);
        @(posedge ph1);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        chk("ld_ready_before_byte", {31'd0, ld_ready}, 32'd1);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = 8'($urandom);
    endtask

    task automatic rd_chk(input logic [7:0] a);
        Adr = a;
        #1;
        if (khi[a]) chk("MemData1", {25'd0, MemData1}, {25'd0, mm[a][14:8]});
        if (klo[a]) chk("MemData2", {24'd0, MemData2}, {24'd0, mm[a][7:0]});
    endtask

    task automatic put_word(input int idx, input logic [7:0] h,
                            input logic [7:0] l);
        mm[idx]  = {h[6:0], l};
        khi[idx] = 1'b1;
        klo[idx] = 1'b1;
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        Adr      = a;
        MemWrite = 1'b1;
        core_en  = 1'b1;
        core_dat = d;
        #1;
        chk("bus_during_store", {24'd0, MemData2}, {24'd0, d});
        tick();
        MemWrite = 1'b0;
        core_en  = 1'b0;
        mm[a][7:0] = d;
        klo[a]     = 1'b1;
    endtask

    logic [7:0] plan [6];
    logic [7:0] h;
    logic [7:0] l;
    logic [7:0] d;
    logic [7:0] a;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mm[i]  = 15'd0;
            khi[i] = 1'b0;
            klo[i] = 1'b0;
        end
        reset      = 1'b1;
        Adr        = 8'd0;
        MemWrite   = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = 8'd0;
        ld_last    = 1'b0;
        reload_req = 1'b0;
        core_en    = 1'b0;
        core_dat   = 8'd0;

        // Reset state.
        tick();
        tick();
        tick();
        reset = 1'b0;
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("rst_run", {31'd0, run}, 32'd0);
        chk("rst_ld_count", {24'd0, ld_count}, 32'd0);

        // Three-word program, last flag on the sixth byte.
        plan[0] = 8'h12; plan[1] = 8'h34;
        plan[2] = 8'h7F; plan[3] = 8'h01;
        plan[4] = 8'h05; plan[5] = 8'hAA;
        for (int i = 0; i < 6; i++) begin
            send(plan[i], i == 5);
            if (i == 4) begin
                chk("cpu_reset_mid", {31'd0, cpu_reset}, 32'd1);
            end
        end
        for (int w = 0; w < 3; w++) put_word(w, plan[2*w], plan[2*w+1]);
        chk("prog_ld_count", {24'd0, ld_count}, 32'd3);
        chk("prog_run", {31'd0, run}, 32'd1);
        chk("prog_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("prog_ld_ready", {31'd0, ld_ready}, 32'd0);
        for (int w = 0; w < 3; w++) rd_chk(8'(w));

        // Directed store to word 2.
        tick();
        store(8'h02, 8'hC3);
        rd_chk(8'h02);

        // Reload coincident with a store: the store still lands.
        tick();
        d = 8'($urandom);
        reload_req = 1'b1;
        store(8'h10, d);
        reload_req = 1'b0;
        chk("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("reload_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("reload_ld_count", {24'd0, ld_count}, 32'd0);
        chk("reload_run", {31'd0, run}, 32'd0);
        rd_chk(8'h10);

        // Idle cycles between hi and lo bytes.
        tick();
        h = 8'($urandom);
        l = 8'($urandom);
        send(h, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_ld_count", {24'd0, ld_count}, 32'd0);
            chk("stall_run", {31'd0, run}, 32'd0);
            rd_chk(8'h00);
            tick();
        end
        send(l, 1'b0);
        put_word(0, h, l);
        chk("stall_done_count", {24'd0, ld_count}, 32'd1);
        rd_chk(8'h00);

        // Word 1, then a hi byte, then reset mid-load.
        h = 8'($urandom);
        l = 8'($urandom);
        send(h, 1'b0);
        send(l, 1'b0);
        put_word(1, h, l);
        chk("word1_count", {24'd0, ld_count}, 32'd2);
        send(8'($urandom), 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_ld_count", {24'd0, ld_count}, 32'd0);
        chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("midrst_run", {31'd0, run}, 32'd0);
        chk("midrst_ld_ready", {31'd0, ld_ready}, 32'd1);
        rd_chk(8'h00);
        rd_chk(8'h01);
        rd_chk(8'h02);

        // Full 256-word image, random gaps; ld_last only on hi bytes,
        // where it must be ignored.
        tick();
        for (int w = 0; w < 256; w++) begin
            h = 8'($urandom);
            l = 8'($urandom);
            send(h, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
            send(l, 1'b0);
            put_word(w, h, l);
            chk("full_ld_count", {24'd0, ld_count}, 32'((w + 1) % 256));
            chk("full_run", {31'd0, run}, {31'd0, w == 255});
            chk("full_cpu_reset", {31'd0, cpu_reset}, {31'd0, w != 255});
        end
        for (int i = 0; i < 256; i++) rd_chk(8'(i));

        // Loader traffic in RUN is ignored.
        tick();
        ld_valid = 1'b1;
        ld_data  = 8'($urandom);
        ld_last  = 1'b1;
        tick();
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("run_ignore_count", {24'd0, ld_count}, 32'd0);
        chk("run_ignore_run", {31'd0, run}, 32'd1);

        // Random stores with read-back the next cycle.
        for (int i = 0; i < 40; i++) begin
            tick();
            a = 8'($urandom);
            d = 8'($urandom);
            store(a, d);
            rd_chk(a);
            rd_chk(8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hmmm_mem_server.md
# hmmm_mem_server

Memory responder for the 8-bit HMMM-style core: owns the 256 x 15-bit unified instruction/data memory and answers the core's Adr/MemWrite/MemData1/MemData2 bus. It also contains a byte-stream program loader that fills memory from address 0 while holding the core in reset, then releases the core to run. It sits at top level beside the core, which connects to it directly.

## Interface

- No parameters; word depth 256, word width 15 (fixed by the core's bus).

- ph1  in  1  two-phase clock, phase 1 (state update).
- ph2  in  1  two-phase clock, phase 2 (sampling, memory write).
- reset  in  1  synchronous, active-high.
- Adr  in  8  core address.
- MemWrite  in  1  core store strobe.
- MemData1  out  7  word bits [14:8] of mem[Adr].
- MemData2  inout  8  word bits [7:0]; driven by this block when not a RUN-state store, high-Z otherwise.
- cpu_reset  out  1  reset to the core.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_last  in  1  marks final word; sampled with the low byte only.
- ld_ready  out  1  loader may accept a byte this cycle.
- reload_req  in  1  restart loading from RUN.
- ld_count  out  8  next load address (words written so far, mod 256).
- run  out  1  high in RUN state.

## Operation

- Cycle = one ph1/ph2 pair. All registers are two-phase flops: they sample on ph2 and update on ph1. Reset is sampled on ph2 with the other inputs.
- States: LOAD_HI, LOAD_LO, RUN. Reset forces LOAD_HI, waddr=0, hi=0. The memory array is not cleared.
- LOAD_HI: ld_ready=1. On ld_valid, hi <= ld_data[6:0] (bit 7 dropped) and go to LOAD_LO. ld_last is ignored in this state.
- LOAD_LO: ld_ready=1. On ld_valid, mem[waddr] <= {hi, ld_data} and waddr <= waddr+1.
  - Go to RUN if ld_last=1 or waddr==255.
  - Otherwise return to LOAD_HI.
  - waddr wraps from 255 to 0 on entering RUN.
- RUN: ld_ready=0; ld_valid is ignored.
  - reload_req=1 → LOAD_HI, waddr=0.
  - A store in the same cycle as reload_req still completes.
- No ld_valid in a LOAD state → state holds (stall).
- reset dominates reload_req and loader traffic. Reset in mid-load discards the partial hi byte; words already written stay in memory.
- cpu_reset = registered (next_state != RUN). It is 1 throughout loading and drops on the same ph1 edge that enters RUN.
- Read path is combinational, with no latency:
  - MemData1 = mem[Adr][14:8].
  - MemData2 = mem[Adr][7:0] whenever its driver is enabled.
- Store: when run & MemWrite, the block tri-states MemData2 and latches mem[Adr][7:0] <= MemData2 while ph2 is high. Bits [14:8] are preserved.
- MemWrite outside RUN is ignored; the block keeps driving the bus.
- run = (state==RUN). ld_count = waddr.

## Timing

- Reset values: state LOAD_HI, cpu_reset=1, ld_ready=1, run=0, ld_count=0.
- Reads: MemData valid one combinational delay after Adr. The core samples it on ph2 of the same cycle.
- Load word: minimum 2 cycles (hi byte, lo byte). The word is written on the ph2 that samples the lo byte and is readable the next cycle.
- The last word's lo-byte accept cycle is followed by RUN and cpu_reset=0 starting the next ph1. The core fetches address 0 in its first unreset cycle.
- Loader handshake: a byte transfers on a ph2 where ld_valid & ld_ready. The source may hold ld_valid high across cycles; each accept consumes exactly one byte.
- Stores: data is written during ph2 of the store cycle. A load from the same address in the following cycle returns the new data.

## Test plan

- Reset, then load bytes 0x12,0x34 / 0x7F,0x01 / 0x05,0xAA (last) → ld_count=3. cpu_reset=0 from the cycle after the 6th accept. Adr=0 reads MemData1=0x12, MemData2=0x34. Adr=1 reads 0x7F/0x01 (hi bit 7 dropped from 0x7F not needed). Adr=2 reads 0x05/0xAA.
- 512 bytes with ld_last never set → RUN entered after word 255, ld_count=0. mem[255] holds the final pair.
- In RUN, MemWrite=1, Adr=0x02, core drives 0xC3 → next cycle Adr=0x02 reads MemData2=0xC3, MemData1=0x05 unchanged. The block never drives MemData2 during the store.
- Insert 3 idle cycles between hi and lo bytes → state holds LOAD_LO, no write occurs until the lo byte is accepted, and the word is correct.
- In RUN, reload_req coincident with a store to 0x10 → store lands. Next cycle cpu_reset=1, ld_ready=1, ld_count=0.
- Assert reset after 3 bytes of loading → state LOAD_HI, ld_count=0, cpu_reset=1. Word 0 still reads its loaded value; the partial hi byte is not written.
